// File: rtl/icache_refill_axi_pkg.sv
// rtl/icache_refill_axi_pkg.sv - shared AXI and icache refill types
package icache_refill_axi_pkg;

  localparam int ICACHE_LINE_SIZE  = 32;
  localparam int ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } icache_refill_state_t;

endpackage

// File: rtl/icache_refill_axi.sv
// rtl/icache_refill_axi.sv - AXI4 read master refilling one icache line per miss
module icache_refill_axi
  import icache_refill_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  output logic                       line_valid,
  output logic [32*LINE_WORDS-1:0]   line_data,
  output logic                       line_err,
  output logic [3:0]                 m_arid,
  output logic [31:0]                m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [3:0]                 m_rid,
  input  logic [31:0]                m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  input  logic                       m_rvalid,
  output logic                       m_rready
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LINE_WORDS);

  icache_refill_state_t state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [31:0]          words_q [LINE_WORDS];
  logic [31:0]          words_d [LINE_WORDS];
  logic                 beat;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^req_addr[4:0];
  assign beat = m_rvalid && m_rready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    words_d = words_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[31:5], 5'b0};
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          // Overrun beats are still drained so the slave can reach rlast.
          if (cnt_q < FULL_CNT) begin
            words_d[cnt_q[IDX_W-1:0]] = m_rdata;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (m_rresp != AXI_RESP_OKAY || m_rid != AXI_ID) err_d = 1'b1;
          if (m_rlast) begin
            state_d = DONE;
            if (cnt_q != LAST_BEAT) err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign m_arvalid  = (state_q == ADDR);
  assign m_rready   = (state_q == DATA);
  assign line_valid = (state_q == DONE);
  assign line_err   = line_valid && err_q;

  assign m_arid    = AXI_ID;
  assign m_araddr  = addr_q;
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
    assign line_data[32*k +: 32] = words_q[k];
  end

endmodule

// File: tb/tb_icache_refill_axi.sv
// tb/tb_icache_refill_axi.sv - self-checking bench for the icache refill master
module tb_icache_refill_axi;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic         line_valid, line_err;
  logic [255:0] line_data;
  logic [3:0]   m_arid, m_rid;
  logic [31:0]  m_araddr, m_rdata;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst, m_rresp;
  logic         m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  always #5 clk = ~clk;

  icache_refill_axi dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .line_valid(line_valid), .line_data(line_data), .line_err(line_err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour for the current refill.
  int          ar_delay = 0;
  int          nbeats = 8;
  int          resp_beat = -1;
  int          rid_beat = -1;
  bit          gap = 1'b0;
  logic [31:0] data_base = 32'h0;
  logic [31:0] exp_araddr = 32'h0;

  // Model: the line the icache should hold, and pending expected completions.
  logic [31:0]  model_words [8];
  logic [255:0] exp_line_q [$];
  bit           exp_err_q [$];

  int           beat_idx = -1;
  int           lines_seen = 0;
  int           accepts = 0;
  bit           chk_lat = 1'b0;
  bit           chk_b2b = 1'b0;
  int           acc_cyc = 0;
  int           last_lv_cyc = -100;
  bit           prev_lv = 1'b0;
  logic [255:0] last_line = '0;
  bit           got_err = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  initial for (int i = 0; i < 8; i++) model_words[i] = 32'h0;

  // AXI slave plus expectation builder.
  initial begin
    int waited;
    logic [255:0] nl;
    bit ne;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rid = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst && m_arvalid) begin
        waited = 0;
        while (waited < ar_delay && !rst) begin
          @(posedge clk); #2;
          waited++;
        end
        if (!rst) begin
          m_arready = 1'b1;
          @(posedge clk); #2;
          m_arready = 1'b0;
          for (int k = 0; k < nbeats && !rst; k++) begin
            if (gap && k > 0) begin
              m_rvalid = 1'b0;
              @(posedge clk); #2;
              if (rst) break;
            end
            beat_idx = k;
            m_rvalid = 1'b1;
            m_rdata  = data_base + 32'(k);
            m_rresp  = (k == resp_beat) ? 2'b10 : 2'b00;
            m_rid    = (k == rid_beat) ? 4'h5 : 4'h0;
            m_rlast  = (k == nbeats - 1);
            if (k == nbeats - 1) begin
              for (int j = 0; j < 8 && j < nbeats; j++) model_words[j] = data_base + 32'(j);
              for (int j = 0; j < 8; j++) nl[32*j +: 32] = model_words[j];
              ne = (nbeats != 8) || (resp_beat >= 0 && resp_beat < nbeats) ||
                   (rid_beat >= 0 && rid_beat < nbeats);
              exp_line_q.push_back(nl);
              exp_err_q.push_back(ne);
            end
            @(posedge clk); #2;
          end
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
          beat_idx = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_line_q.delete();
      exp_err_q.delete();
      for (int i = 0; i < 8; i++) model_words[i] = 32'h0;
      last_line = '0;
      prev_lv = 1'b0;
    end else begin
      chk("one_phase", 256'($countones({req_ready, m_arvalid, m_rready, line_valid})), 256'd1);
      if (m_arvalid) begin
        chk("araddr", m_araddr, exp_araddr);
        chk("arlen", m_arlen, 8'd7);
        chk("arsize", m_arsize, 3'd2);
        chk("arburst", m_arburst, 2'd1);
        chk("arid", m_arid, 4'd0);
      end
      if (line_valid) begin
        chk("line_valid_single", prev_lv, 1'b0);
        if (exp_line_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_line_valid: got line_valid=1 required no completion");
        end else begin
          chk("line_data", line_data, exp_line_q.pop_front());
          chk("line_err", line_err, exp_err_q.pop_front());
        end
        if (chk_lat) chk("latency", cyc - acc_cyc, 10);
        last_line = line_data;
        got_err = line_err;
        last_lv_cyc = cyc;
        lines_seen++;
      end else if (req_ready) begin
        chk("line_hold", line_data, last_line);
      end
      if (req_valid && req_ready) begin
        if (chk_b2b) chk("b2b_accept", cyc, last_lv_cyc + 1);
        accepts++;
        acc_cyc = cyc;
      end
      prev_lv = line_valid;
    end
  end

  task automatic do_req(input logic [31:0] a);
    int start;
    int n;
    start = accepts;
    @(posedge clk); #2;
    req_valid = 1'b1;
    req_addr = a;
    exp_araddr = {a[31:5], 5'b0};
    n = 0;
    while (accepts == start && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (accepts == start) timeout_fail("req_accept");
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_lines(input int target);
    int n;
    n = 0;
    while (lines_seen < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (lines_seen < target) timeout_fail("line_wait");
  endtask

  initial begin
    int n;
    int start;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int start;
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_err", line_err, 1'b0);
    chk("rst_line_data", line_data, 256'h0);
    chk("rst_araddr", m_araddr, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Best case, unaligned miss address.
    data_base = 32'h100;
    chk_lat = 1'b1;
    do_req(32'h0000_1234);
    wait_lines(1);
    chk_lat = 1'b0;
    chk("t1_araddr", m_araddr, 32'h0000_1220);
    chk("t1_word0", last_line[31:0], 32'h100);
    chk("t1_word3", last_line[127:96], 32'h103);
    chk("t1_err", got_err, 1'b0);

    // AR stall and R gaps.
    ar_delay = 5; gap = 1'b1; data_base = 32'h200;
    do_req(32'h0000_4400);
    wait_lines(2);
    ar_delay = 0; gap = 1'b0;
    chk("t2_word7", last_line[255:224], 32'h207);

    // SLVERR on beat 3, then bad RID on beat 6.
    resp_beat = 3; data_base = 32'h300;
    do_req(32'h0000_5000);
    wait_lines(3);
    resp_beat = -1;
    chk("t3_err", got_err, 1'b1);
    chk("t3_word7", last_line[255:224], 32'h307);
    rid_beat = 6; data_base = 32'h380;
    do_req(32'h0000_5020);
    wait_lines(4);
    rid_beat = -1;
    chk("t3b_err", got_err, 1'b1);

    // Short burst keeps the tail of the previous line.
    nbeats = 5; data_base = 32'h400;
    do_req(32'h0000_6040);
    wait_lines(5);
    chk("t4a_word4", last_line[159:128], 32'h404);
    chk("t4a_word5", last_line[191:160], 32'h385);
    chk("t4a_err", got_err, 1'b1);
    nbeats = 10; data_base = 32'h500;
    do_req(32'h0000_6080);
    wait_lines(6);
    nbeats = 8;
    chk("t4b_word7", last_line[255:224], 32'h507);
    chk("t4b_err", got_err, 1'b1);

    // Reset during beat 4.
    data_base = 32'h600;
    do_req(32'h0000_7000);
    n = 0;
    while (beat_idx != 4 && n < 100) begin
      @(posedge clk); #3;
      n++;
    end
    if (beat_idx != 4) timeout_fail("t5_beat4");
    rst = 1'b1;
    #1;
    chk("t5_req_ready", req_ready, 1'b1);
    chk("t5_rready", m_rready, 1'b0);
    chk("t5_line_valid", line_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("t5_line_cleared", line_data, 256'h0);
    data_base = 32'h700;
    do_req(32'h0000_7000);
    wait_lines(7);
    chk("t5_word2", last_line[95:64], 32'h702);
    chk("t5_err", got_err, 1'b0);

    // Back-to-back refills with req_valid held.
    data_base = 32'h800;
    start = accepts;
    @(posedge clk); #2;
    req_valid = 1'b1;
    req_addr = 32'h0000_8000;
    exp_araddr = 32'h0000_8000;
    n = 0;
    while (accepts == start && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (accepts == start) timeout_fail("t6_first_accept");
    chk_b2b = 1'b1;
    wait_lines(9);
    n = 0;
    while (accepts < start + 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (accepts < start + 3) timeout_fail("t6_third_accept");
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_lines(10);
    chk_b2b = 1'b0;
    repeat (5) @(posedge clk);
    chk("t6_accepts", accepts - start, 3);
    chk("drained", exp_line_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_axi.md
# icache_refill_axi

AXI4 read master that performs instruction-cache line refills. Sits directly downstream of the icache miss logic and upstream of the AXI memory port. Accepts one miss address and issues a single 8-beat INCR burst of 4-byte beats for the enclosing 32-byte line. Returns the assembled 256-bit line to the icache in one cycle, with an error flag.

## Interface

- `AXI_ID`, default 0: value driven on `m_arid`; also the expected `m_rid`.
- `LINE_WORDS`, default `ICACHE_LINE_SIZE/4` (8): beats per refill.

Ports:

- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: one clock; reset is asynchronous and active-high.
- `req_valid`, in, 1: icache requests a refill.
- `req_ready`, out, 1: block idle and able to accept a request.
- `req_addr`, in, 32: miss address; bits [4:0] ignored.
- `line_valid`, out, 1: one-cycle pulse; line is complete.
- `line_data`, out, 256: word k at bits [32k+31:32k], where k is the beat index.
- `line_err`, out, 1: refill faulted; qualified by `line_valid`.
- `m_arid`, out, 4: AR ID.
- `m_araddr`, out, 32: AR address.
- `m_arlen`, out, 8: AR burst length.
- `m_arsize`, out, 3: AR beat size.
- `m_arburst`, out, 2: AR burst type.
- `m_arvalid`, out, 1: AR valid.
- `m_arready`, in, 1: AR ready.
- `m_rid`, in, 4: R ID.
- `m_rdata`, in, 32: R data.
- `m_rresp`, in, 2: R response.
- `m_rlast`, in, 1: R last beat.
- `m_rvalid`, in, 1: R valid.
- `m_rready`, out, 1: R ready.

## Operation

FSM states: `IDLE`, `ADDR`, `DATA`, `DONE`.

- **IDLE**
  - `req_ready=1`.
  - On `req_valid`: latch `{req_addr[31:5],5'b0}` into `m_araddr`, clear beat counter and error flag, go to ADDR.
- **ADDR**
  - `m_arvalid=1`.
  - AR fields held stable until handshake: `m_arlen=LINE_WORDS-1` (7), `m_arsize=AXI_SIZE_4B`, `m_arburst=AXI_BURST_INCR`.
  - On `m_arready`: go to DATA.
- **DATA**
  - `m_rready=1`.
  - Each beat (`m_rvalid&&m_rready`):
    - If counter < 8: write `m_rdata` into word[counter] and increment the 3-bit+1 counter.
    - Set the error flag if `m_rresp!=AXI_RESP_OKAY` or `m_rid!=AXI_ID`.
  - On a beat with `m_rlast`: go to DONE.
    - If that beat is not the 8th, set the error flag (short burst).
  - Beats after the 8th without `m_rlast` set the error flag; their data is discarded. Keep accepting until `m_rlast`.
- **DONE**
  - `line_valid=1` and `line_err`=error flag for exactly one cycle.
  - Next cycle: go to IDLE.
- `line_data` remains stable from DONE until the next request is accepted.
- No request queueing. `req_valid` outside IDLE is ignored (`req_ready=0`).

## Timing

- Reset values:
  - State is IDLE, so `req_ready=1`.
  - `m_arvalid=0`, `m_rready=0`, `line_valid=0`, `line_err=0`.
  - `line_data=0`, `m_araddr=0`, counter=0.
  - `m_arid/m_arlen/m_arsize/m_arburst` are constants.
- `req_ready`, `m_arvalid` and `m_rready` decode from registered state. No combinational path from any input.
- Best-case latency:
  - Request accepted at cycle 0.
  - `m_arvalid` high in cycle 1. Handshake in cycle 1 if `m_arready=1`.
  - Beats arrive in cycles 2–9.
  - `line_valid` in cycle 10.
  - Next request accepted in cycle 11.
- Stalls:
  - `m_rvalid` gaps stall DATA with no state change.
  - `m_arready=0` holds ADDR indefinitely with AR fields unchanged.
- Reset mid-burst: the block returns to IDLE immediately and asserts no `line_valid`. The AXI slave shares `rst`, so no stale beats arrive afterwards.

## Structure

- Add `ICACHE_LINE_WORDS = ICACHE_LINE_SIZE/4` to the shared package.
- Add refill FSM enum `icache_refill_state_t` to the shared package.
- Reuse the package's existing `axi_burst_type_t`, `axi_size_t` and `axi_resp_t`.
- Single module; no sub-module. The line buffer is an 8×32 register array inside the module.

## Test plan

1. `req_addr=0x0000_1234`, always-ready slave returning data 0x100+k → `m_araddr=0x0000_1220`, `m_arlen=7`, `m_arsize=2`, `m_arburst=1`; `line_valid` in cycle 10; word k = 0x100+k; `line_err=0`.
2. `m_arready` low for 5 cycles; `m_rvalid` alternating 1/0 → AR fields stable throughout; correct line; `line_valid` exactly one cycle.
3. Beat 3 has `m_rresp=SLVERR` → full line returned; `line_err=1`.
4. `m_rlast` on beat 5 → DONE after beat 5; `line_err=1`. Also: 10 beats with `m_rlast` on the 10th → beats 9–10 discarded; `line_err=1`.
5. `rst` asserted during beat 4 → immediately `req_ready=1`, `m_rready=0`, no `line_valid`. A new request after reset refills correctly.
6. `req_valid` held high continuously → back-to-back refills, each accepted exactly one cycle after the previous `line_valid`.
